// File: rtl/z3_pkg.sv
// Shared state encoding, constants and address decode for the Zorro III slave-cycle sequencer.
package z3_pkg;

    typedef enum logic [1:0] {
        Z3_IDLE  = 2'd0,
        Z3_START = 2'd1,
        Z3_DATA  = 2'd2,
        Z3_END   = 2'd3
    } z3_state_t;

    typedef struct packed {
        logic ac;
        logic scsi;
    } z3_hit_t;

    localparam logic [7:0] AUTOCONFIG_BASE_HI     = 8'hFF;
    localparam int         TIMEOUT_CYCLES_DEFAULT = 64;
    localparam int         TIMER_W                = 8;

    // addr_hi is ADDR[31:24]; autoconfig wins so the two hits never overlap.
    function automatic z3_hit_t decode_hit(
        input logic [7:0] addr_hi,
        input logic       cfgin_n,
        input logic       configured,
        input logic       shutup,
        input logic [3:0] base,
        input logic [3:0] space_hi
    );
        z3_hit_t h;
        h.ac   = (addr_hi == AUTOCONFIG_BASE_HI) && !cfgin_n && !configured && !shutup;
        h.scsi = !h.ac && configured && (addr_hi[7:4] == space_hi) && (addr_hi[3:0] == base);
        return h;
    endfunction

endpackage

// File: rtl/z3_bus_fsm_if.sv
// Zorro III bus strobes/address plus the downstream stage handshakes of the slave-cycle sequencer.
interface z3_bus_fsm_if;

    logic        FCS_n;
    logic [3:0]  DS_n;
    logic        READ;
    logic [29:0] ADDR;
    logic        CFGIN_n;
    logic        configured;
    logic        shutup;
    logic [3:0]  scsi_base_addr;
    logic        ac_dtack;
    logic        scsi_ack;

    logic [1:0]  z3_state;
    logic        autoconfig_cycle;
    logic        scsi_cycle;
    logic [6:0]  ADDRL;
    logic        SLAVE_n;
    logic        DTACK_n;
    logic        DOE;
    logic        timeout_err;

    modport master (
        output FCS_n, DS_n, READ, ADDR, CFGIN_n, configured, shutup,
               scsi_base_addr, ac_dtack, scsi_ack,
        input  z3_state, autoconfig_cycle, scsi_cycle, ADDRL, SLAVE_n,
               DTACK_n, DOE, timeout_err
    );

    modport slave (
        input  FCS_n, DS_n, READ, ADDR, CFGIN_n, configured, shutup,
               scsi_base_addr, ac_dtack, scsi_ack,
        output z3_state, autoconfig_cycle, scsi_cycle, ADDRL, SLAVE_n,
               DTACK_n, DOE, timeout_err
    );

endinterface

// File: rtl/z3_sync.sv
// WIDTH-bit, STAGES-deep synchroniser for asynchronous active-low strobes; resets to negated (all ones).
module z3_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    // NOTE: non-blocking so each stage takes its predecessor's value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '1;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/z3_bus_fsm.sv
// Zorro III slave-cycle sequencer: synchronises FCS_n/DS_n, decodes autoconfig/SCSI hits and
// sequences SLAVE_n, DTACK_n and DOE, forcing DTACK_n if the selected stage never acknowledges.
module z3_bus_fsm
    import z3_pkg::*;
#(
    parameter logic [3:0] Z3_SPACE_HI    = 4'h4,
    parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int         SYNC_STAGES    = 2
) (
    input logic         CLK,
    input logic         RESET,
    z3_bus_fsm_if.slave bus
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]         PRIME_DONE = 2'(SYNC_STAGES);

    logic [4:0]         sync_q;
    logic               fcs_s;
    logic [3:0]         ds_s;
    logic               ds_any_low;
    logic               ds_all_high;

    z3_state_t          state, state_d;
    z3_hit_t            hit, hit_d, hit_new;
    logic [6:0]         addrl, addrl_d;
    logic [TIMER_W-1:0] timer, timer_d;
    logic               armed, armed_d;
    logic [1:0]         prime_cnt;
    logic               primed;
    logic               dtack, dtack_d;
    logic               doe_hold, doe_hold_d;
    logic               timeout_err, timeout_d;
    logic               any_hit;
    logic               sel_ack;
    logic               unused_addr;

    z3_sync #(
        .WIDTH  (5),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (CLK),
        .rst (RESET),
        .d   ({bus.FCS_n, bus.DS_n}),
        .q   (sync_q)
    );

    assign fcs_s       = sync_q[4];
    assign ds_s        = sync_q[3:0];
    assign ds_any_low  = (ds_s != 4'hF);
    assign ds_all_high = (ds_s == 4'hF);

    assign hit_new     = decode_hit(bus.ADDR[29:22], bus.CFGIN_n, bus.configured,
                                    bus.shutup, bus.scsi_base_addr, Z3_SPACE_HI);
    assign unused_addr = ^bus.ADDR[21:7];

    assign any_hit = hit.ac | hit.scsi;
    assign sel_ack = hit.ac ? bus.ac_dtack : bus.scsi_ack;
    // The synchroniser's reset value is not a real FCS_n sample, so arming waits until it has flushed.
    assign primed  = (prime_cnt == PRIME_DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= Z3_IDLE;
            hit         <= '0;
            addrl       <= '0;
            timer       <= '0;
            armed       <= 1'b0;
            prime_cnt   <= '0;
            dtack       <= 1'b0;
            doe_hold    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            hit         <= hit_d;
            addrl       <= addrl_d;
            timer       <= timer_d;
            armed       <= armed_d;
            dtack       <= dtack_d;
            doe_hold    <= doe_hold_d;
            timeout_err <= timeout_d;
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state;
        hit_d      = hit;
        addrl_d    = addrl;
        timer_d    = timer;
        armed_d    = armed;
        dtack_d    = dtack;
        doe_hold_d = doe_hold;
        timeout_d  = 1'b0;

        if (primed && fcs_s) begin
            armed_d = 1'b1;
        end

        case (state)
            Z3_IDLE: begin
                timer_d = '0;
                if (armed && !fcs_s) begin
                    state_d = Z3_START;
                    armed_d = 1'b0;
                    addrl_d = bus.ADDR[6:0];
                    hit_d   = hit_new;
                end
            end
            Z3_START: begin
                if (fcs_s) begin
                    state_d = Z3_IDLE;
                    hit_d   = '0;
                end else if (any_hit && ds_any_low) begin
                    state_d = Z3_DATA;
                end
            end
            Z3_DATA: begin
                timer_d = (timer == '1) ? timer : timer + TIMER_W'(1);
                if (fcs_s) begin
                    // Master gave up: drop the cycle without ever asserting DTACK_n.
                    state_d = Z3_IDLE;
                    hit_d   = '0;
                    timer_d = '0;
                end else if (sel_ack || (timer == TIMER_LAST)) begin
                    state_d    = Z3_END;
                    dtack_d    = 1'b1;
                    doe_hold_d = bus.READ;
                    timeout_d  = !sel_ack;
                end
            end
            Z3_END: begin
                if (fcs_s || ds_all_high) begin
                    dtack_d    = 1'b0;
                    doe_hold_d = 1'b0;
                end
                if (fcs_s) begin
                    state_d = Z3_IDLE;
                    hit_d   = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = Z3_IDLE;
            end
        endcase
    end

    assign bus.z3_state         = state;
    assign bus.autoconfig_cycle = hit.ac;
    assign bus.scsi_cycle       = hit.scsi;
    assign bus.ADDRL            = addrl;
    assign bus.SLAVE_n          = !any_hit;
    assign bus.DTACK_n          = !dtack;
    assign bus.DOE              = (state == Z3_DATA) ? (bus.READ & any_hit) : doe_hold;
    assign bus.timeout_err      = timeout_err;

endmodule

// File: tb/tb_z3_bus_fsm.sv
// Directed and randomized bench for z3_bus_fsm against a transaction-level model of the slave cycle.
module tb_z3_bus_fsm;

    localparam int TIMEOUT = 64;
    localparam int SYNC    = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    z3_bus_fsm_if bus ();

    z3_bus_fsm #(
        .Z3_SPACE_HI    (4'h4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Target of a cycle: 0 none, 1 autoconfig, 2 SCSI window.
    function automatic int model_target(input logic [31:0] addr, input logic cfgin_n,
                                        input logic configured, input logic shutup,
                                        input logic [3:0] base);
        if (addr[31:24] == 8'hFF && !cfgin_n && !configured && !shutup) return 1;
        if (configured && addr[31:28] == 4'h4 && addr[27:24] == base) return 2;
        return 0;
    endfunction

    task automatic drive_idle();
        bus.FCS_n    = 1'b1;
        bus.DS_n     = 4'hF;
        bus.ac_dtack = 1'b0;
        bus.scsi_ack = 1'b0;
        bus.READ     = 1'b0;
    endtask

    task automatic start_cycle(input logic [31:0] addr, input logic cfgin_n, input logic configured,
                               input logic shutup, input logic [3:0] base, input logic read,
                               input logic [3:0] ds);
        bus.ADDR           = addr[31:2];
        bus.CFGIN_n        = cfgin_n;
        bus.configured     = configured;
        bus.shutup         = shutup;
        bus.scsi_base_addr = base;
        bus.READ           = read;
        bus.FCS_n          = 1'b0;
        bus.DS_n           = ds;
    endtask

    task automatic check_released(input string tag);
        check($sformatf("%s state", tag),   32'(bus.z3_state), 32'd0);
        check($sformatf("%s ac", tag),      32'(bus.autoconfig_cycle), 32'd0);
        check($sformatf("%s scsi", tag),    32'(bus.scsi_cycle), 32'd0);
        check($sformatf("%s SLAVE_n", tag), 32'(bus.SLAVE_n), 32'd1);
        check($sformatf("%s DTACK_n", tag), 32'(bus.DTACK_n), 32'd1);
        check($sformatf("%s DOE", tag),     32'(bus.DOE), 32'd0);
        check($sformatf("%s tmo", tag),     32'(bus.timeout_err), 32'd0);
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic cfgin_n, input logic configured,
                           input logic shutup, input logic [3:0] base, input logic read,
                           input int delay);
        int         tgt;
        logic [3:0] ds;
        tgt = model_target(addr, cfgin_n, configured, shutup, base);
        ds  = 4'($urandom_range(0, 14));
        start_cycle(addr, cfgin_n, configured, shutup, base, read, ds);
        step(3);
        check("rnd start",   32'(bus.z3_state), 32'd1);
        check("rnd ac",      32'(bus.autoconfig_cycle), 32'(tgt == 1));
        check("rnd scsi",    32'(bus.scsi_cycle), 32'(tgt == 2));
        check("rnd ADDRL",   32'(bus.ADDRL), 32'(addr[8:2]));
        check("rnd SLAVE_n", 32'(bus.SLAVE_n), 32'(tgt == 0));
        step(1);
        if (tgt == 0) begin
            check("rnd miss state",   32'(bus.z3_state), 32'd1);
            check("rnd miss DTACK_n", 32'(bus.DTACK_n), 32'd1);
        end else begin
            check("rnd data state", 32'(bus.z3_state), 32'd2);
            check("rnd data DOE",   32'(bus.DOE), 32'(read));
            for (int i = 0; i < delay; i++) begin
                if (tgt == 1) bus.scsi_ack = 1'b1;
                else          bus.ac_dtack = 1'b1;
                step(1);
                check("rnd wrong ack ignored", 32'(bus.z3_state), 32'd2);
            end
            if (tgt == 1) bus.ac_dtack = 1'b1;
            else          bus.scsi_ack = 1'b1;
            step(1);
            check("rnd end state",   32'(bus.z3_state), 32'd3);
            check("rnd end DTACK_n", 32'(bus.DTACK_n), 32'd0);
            check("rnd end DOE",     32'(bus.DOE), 32'(read));
            check("rnd end tmo",     32'(bus.timeout_err), 32'd0);
            bus.ac_dtack = 1'b0;
            bus.scsi_ack = 1'b0;
        end
        bus.FCS_n = 1'b1;
        bus.DS_n  = 4'hF;
        step(3);
        check_released("rnd release");
    endtask

    initial begin
        int          n;
        logic [31:0] addr;
        logic [3:0]  base;

        drive_idle();
        bus.ADDR           = '0;
        bus.CFGIN_n        = 1'b1;
        bus.configured     = 1'b0;
        bus.shutup         = 1'b0;
        bus.scsi_base_addr = 4'h0;
        rst = 1'b1;
        step(3);
        check_released("reset");
        check("reset ADDRL", 32'(bus.ADDRL), 32'd0);
        rst = 1'b0;
        step(4);

        // Autoconfig read.
        start_cycle(32'hFF000044, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0000);
        step(2);
        check("ac before latency", 32'(bus.z3_state), 32'd0);
        step(1);
        check("ac start",   32'(bus.z3_state), 32'd1);
        check("ac hit",     32'(bus.autoconfig_cycle), 32'd1);
        check("ac scsi",    32'(bus.scsi_cycle), 32'd0);
        check("ac ADDRL",   32'(bus.ADDRL), 32'h11);
        check("ac SLAVE_n", 32'(bus.SLAVE_n), 32'd0);
        step(1);
        check("ac data",       32'(bus.z3_state), 32'd2);
        check("ac data DOE",   32'(bus.DOE), 32'd1);
        check("ac data DTACK", 32'(bus.DTACK_n), 32'd1);
        step(1);
        check("ac data hold", 32'(bus.z3_state), 32'd2);
        bus.ac_dtack = 1'b1;
        step(1);
        check("ac end",       32'(bus.z3_state), 32'd3);
        check("ac DTACK_n",   32'(bus.DTACK_n), 32'd0);
        check("ac end DOE",   32'(bus.DOE), 32'd1);
        check("ac end tmo",   32'(bus.timeout_err), 32'd0);
        bus.ac_dtack = 1'b0;
        bus.DS_n     = 4'hF;
        step(2);
        check("ac DTACK held", 32'(bus.DTACK_n), 32'd0);
        step(1);
        check("ac DS release DTACK", 32'(bus.DTACK_n), 32'd1);
        check("ac DS release DOE",   32'(bus.DOE), 32'd0);
        check("ac still END",        32'(bus.z3_state), 32'd3);
        check("ac SLAVE_n held",     32'(bus.SLAVE_n), 32'd0);
        bus.FCS_n = 1'b1;
        step(3);
        check_released("ac release");

        // SCSI write; the autoconfig ack must not terminate it.
        start_cycle(32'h42000010, 1'b0, 1'b1, 1'b0, 4'h2, 1'b0, 4'b0011);
        step(3);
        check("scsi hit",     32'(bus.scsi_cycle), 32'd1);
        check("scsi ac",      32'(bus.autoconfig_cycle), 32'd0);
        check("scsi SLAVE_n", 32'(bus.SLAVE_n), 32'd0);
        check("scsi ADDRL",   32'(bus.ADDRL), 32'h04);
        step(1);
        check("scsi data", 32'(bus.z3_state), 32'd2);
        check("scsi DOE",  32'(bus.DOE), 32'd0);
        bus.ac_dtack = 1'b1;
        step(2);
        check("scsi ignores ac_dtack", 32'(bus.DTACK_n), 32'd1);
        bus.scsi_ack = 1'b1;
        step(1);
        check("scsi DTACK_n", 32'(bus.DTACK_n), 32'd0);
        check("scsi end DOE", 32'(bus.DOE), 32'd0);
        drive_idle();
        step(2);
        check("scsi DTACK held", 32'(bus.DTACK_n), 32'd0);
        step(1);
        check_released("scsi release");

        // Miss: stays in START with no response even with acks offered.
        start_cycle(32'h43000000, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 4'b0000);
        bus.ac_dtack = 1'b1;
        bus.scsi_ack = 1'b1;
        step(3);
        for (int i = 0; i < 5; i++) begin
            check("miss state",   32'(bus.z3_state), 32'd1);
            check("miss SLAVE_n", 32'(bus.SLAVE_n), 32'd1);
            check("miss DTACK_n", 32'(bus.DTACK_n), 32'd1);
            step(1);
        end
        drive_idle();
        step(3);
        check_released("miss release");

        // Timeout with both acks held low.
        start_cycle(32'h42000000, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 4'b0000);
        step(4);
        n = 0;
        while (bus.z3_state == 2'd2 && n < 300) begin
            check("tmo DTACK idle", 32'(bus.DTACK_n), 32'd1);
            n++;
            step(1);
        end
        check("tmo data cycles", 32'(n), 32'(TIMEOUT));
        check("tmo end state",   32'(bus.z3_state), 32'd3);
        check("tmo DTACK_n",     32'(bus.DTACK_n), 32'd0);
        check("tmo pulse",       32'(bus.timeout_err), 32'd1);
        step(1);
        check("tmo pulse width", 32'(bus.timeout_err), 32'd0);
        check("tmo DTACK hold",  32'(bus.DTACK_n), 32'd0);
        drive_idle();
        step(3);
        check_released("tmo release");

        // Abort mid-DATA.
        start_cycle(32'h42000000, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, 4'b0000);
        step(5);
        check("abort in data", 32'(bus.z3_state), 32'd2);
        bus.FCS_n = 1'b1;
        step(2);
        check("abort no DTACK", 32'(bus.DTACK_n), 32'd1);
        step(1);
        check_released("abort");
        bus.DS_n = 4'hF;
        step(1);

        // Reset while FCS_n is low: no START until FCS_n toggles.
        start_cycle(32'hFF000000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0000);
        step(3);
        check("rst pre START", 32'(bus.z3_state), 32'd1);
        rst = 1'b1;
        step(1);
        check_released("rst mid-cycle");
        check("rst ADDRL", 32'(bus.ADDRL), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("rst ignores low FCS_n", 32'(bus.z3_state), 32'd0);
        end
        bus.FCS_n = 1'b1;
        step(3);
        bus.FCS_n = 1'b0;
        step(2);
        check("rst rearm latency", 32'(bus.z3_state), 32'd0);
        step(1);
        check("rst rearm START", 32'(bus.z3_state), 32'd1);
        drive_idle();
        step(3);
        check_released("rst rearm release");

        // Shutup and configured both gate autoconfig.
        for (int k = 0; k < 2; k++) begin
            start_cycle(32'hFF000000, 1'b0, (k == 1), (k == 0), 4'h2, 1'b1, 4'b0000);
            step(4);
            check("gate state",   32'(bus.z3_state), 32'd1);
            check("gate ac",      32'(bus.autoconfig_cycle), 32'd0);
            check("gate SLAVE_n", 32'(bus.SLAVE_n), 32'd1);
            drive_idle();
            step(3);
            check_released("gate release");
        end

        // Randomized back-to-back transactions.
        for (int t = 0; t < 40; t++) begin
            base = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       addr = {8'hFF, 24'($urandom)};
                1:       addr = {4'h4, base, 24'($urandom)};
                2:       addr = {4'h4, 4'($urandom), 24'($urandom)};
                default: addr = $urandom;
            endcase
            run_txn(addr, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), base, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 6)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/z3_bus_fsm.md
Name: z3_bus_fsm

Overview:
- Zorro III slave-cycle sequencer, directly upstream of the autoconfig and SCSI register stages.
- Synchronises FCS_n/DS_n and decodes the externally FCS-latched address into autoconfig or SCSI-window hits.
- Drives the 2-bit z3_state, autoconfig_cycle, scsi_cycle and ADDRL consumed downstream.
- Sequences SLAVE_n, DTACK_n and DOE, with a bus-hang timeout.

Parameters:
- Z3_SPACE_HI, 4'h4, value required on ADDR[31:28] for a SCSI-window hit.
- TIMEOUT_CYCLES, 64, CLK cycles in DATA before forced DTACK (2..255).
- SYNC_STAGES, 2, synchroniser depth for FCS_n and DS_n (2 or 3).

Ports:
- CLK  in  1  board clock
- RESET  in  1  synchronous, active-high reset
- FCS_n  in  1  Zorro III full cycle strobe (async)
- DS_n  in  4  data strobes (async)
- READ  in  1  bus read/write
- ADDR  in  30  ADDR[31:2], demultiplexed address, latched externally on FCS_n fall
- CFGIN_n  in  1  autoconfig chain input
- configured  in  1  from autoconfig stage
- shutup  in  1  from autoconfig stage
- scsi_base_addr  in  4  assigned base nibble, compared with ADDR[27:24]
- ac_dtack  in  1  autoconfig stage ready
- scsi_ack  in  1  SCSI register stage ready
- z3_state  out  2  IDLE=0, START=1, DATA=2, END=3
- autoconfig_cycle  out  1  current cycle targets autoconfig space
- scsi_cycle  out  1  current cycle targets SCSI window
- ADDRL  out  7  ADDR[8:2] captured in START
- SLAVE_n  out  1  board-responding indicator
- DTACK_n  out  1  cycle termination
- DOE  out  1  data bus drive enable
- timeout_err  out  1  one-cycle pulse on forced termination

Behaviour:
- Reset (synchronous, sampled on CLK rising edge):
  - z3_state=IDLE; autoconfig_cycle=0, scsi_cycle=0, ADDRL=0.
  - SLAVE_n=1, DTACK_n=1, DOE=0, timeout_err=0.
  - Synchronisers reset to 1 (negated); timeout counter cleared; armed=0.
- armed:
  - Sets when synced FCS_n is high.
  - IDLE->START is allowed only while armed, so a cycle already in progress when reset releases is ignored until FCS_n negates.
- IDLE -> START: when armed and synced FCS_n=0. On that edge:
  - Capture ADDRL.
  - Set autoconfig_cycle = (ADDR[31:24]==8'hFF) & !CFGIN_n & !configured & !shutup.
  - Set scsi_cycle = configured & (ADDR[31:28]==Z3_SPACE_HI) & (ADDR[27:24]==scsi_base_addr).
  - The two hits are mutually exclusive; autoconfig has priority.
- START:
  - SLAVE_n=0 while either hit is set.
  - Go to DATA when a hit is set and any synced DS_n bit is 0.
  - With no hit, remain in START with no outputs until FCS_n negates, then IDLE.
- DATA:
  - DOE = READ & hit.
  - Timeout counter increments each cycle.
  - When the selected ack (ac_dtack for autoconfig, scsi_ack for SCSI) is 1, DTACK_n goes 0 on the next edge and state goes to END.
  - If the counter reaches TIMEOUT_CYCLES-1 first: same transition, plus timeout_err pulses for exactly one cycle.
- END:
  - DTACK_n and DOE hold until all synced DS_n are 1 or FCS_n is 1.
  - On that event, DTACK_n=1 and DOE=0 in the same cycle.
  - On synced FCS_n=1: go to IDLE, clear hits, set SLAVE_n=1, clear counter.
- FCS_n negating in START or DATA (aborted cycle): IDLE next edge, all outputs negated, no DTACK_n, no timeout_err.
- Back-to-back: FCS_n high for at least one synced sample is required before a new START.
- Latency: FCS_n fall to START is SYNC_STAGES+1 edges; ack to DTACK_n low is 1 edge.
- RESET asserted in any state: all outputs take reset values on that edge.
- The counter saturates and never wraps.

Decomposition:
- Shared package z3_pkg:
  - z3_state_t encoding (IDLE/START/DATA/END).
  - AUTOCONFIG_BASE_HI=8'hFF.
  - Default TIMEOUT_CYCLES.
- Sub-module z3_sync: parameterised-depth, N-bit synchroniser with reset value 1, instanced for {FCS_n, DS_n}.

Test Plan:
- Autoconfig read:
  - Stimulus: RESET, CFGIN_n=0, ADDR=32'hFF000044, FCS_n low, then DS_n=4'b0000 with READ=1, ac_dtack=1 one edge after DATA.
  - Response: sequence IDLE->START->DATA->END; autoconfig_cycle=1; ADDRL=7'h11; DOE=1; DTACK_n low 1 edge after ack; all outputs released after DS_n/FCS_n high.
- SCSI hit:
  - Stimulus: configured=1, scsi_base_addr=4'h2, ADDR=32'h42000010, READ=0.
  - Response: scsi_cycle=1, SLAVE_n=0, DOE=0, DTACK_n tracks scsi_ack.
- Miss:
  - Stimulus: configured=1, ADDR=32'h43000000, base 4'h2.
  - Response: z3_state never leaves START; SLAVE_n and DTACK_n stay 1; IDLE after FCS_n high.
- Timeout:
  - Stimulus: hit with acks held 0.
  - Response: DTACK_n low after 64 DATA cycles; timeout_err high exactly 1 cycle.
- Abort and reset:
  - Stimulus 1: FCS_n high mid-DATA.
  - Response 1: IDLE next edge, no DTACK_n.
  - Stimulus 2: RESET pulsed while FCS_n is low.
  - Response 2: no START until FCS_n toggles high then low.
- Shutup/configured gating:
  - Stimulus: shutup=1 with ADDR=32'hFF000000 and CFGIN_n=0.
  - Response: autoconfig_cycle=0, no response.
